key_event_ctrl: RTL and testbench
=================================

# key_event_ctrl

Debounces the board's 4 push-keys and 4 slide-switches and turns their changes into maskable, latched events. It drives one interrupt request to the ez8 core. It sits on the peripheral bus as a 4-register, 8-bit device and supersedes raw switch/key polling. Software reads the debounced state, takes pending events, and clears them with write-1-to-clear.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required before a bit change is accepted. Legal range is ≥2.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `keys`  in  4  raw push-keys, active-low (idle = 1), asynchronous to `clk`
- `switches`  in  4  raw slide-switches, asynchronous to `clk`
- `addr`  in  2  register select: 0 STATE, 1 PENDING, 2 MASK, 3 EDGE_MODE
- `write_en`  in  1  one-cycle write strobe
- `writedata`  in  8  write data
- `readdata`  out  8  registered read data for `addr`
- `irq`  out  1  registered level interrupt, high while `|(PENDING & MASK)`

## Operation
- Input vector is `in = {switches, keys}`. Bit i of every register corresponds to `in[i]`.
- Per bit: a 2-flop synchronizer feeds `sync[i]`.
  - Stability counter is `$clog2(DEBOUNCE_CYCLES)` bits wide.
  - If `sync[i] == STATE[i]`, the counter is cleared to 0.
  - If they differ and counter == `DEBOUNCE_CYCLES-1`: `STATE[i] <= sync[i]` and the counter returns to 0. This is an accept event.
  - If they differ otherwise: counter +1.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes STATE.
- Event qualification on accept of bit i:
  - EDGE_MODE[i] = 0: any change sets PENDING[i].
  - EDGE_MODE[i] = 1: only a 1→0 transition sets PENDING[i] (key press).
- PENDING is sticky.
  - A write to addr 1 clears the bits where `writedata` = 1. Bits where `writedata` = 0 are unchanged.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- MASK and EDGE_MODE are plain read/write registers. A write to addr 0 is ignored (STATE is read-only).
- Reads have no side effects.
- MASK does not gate PENDING latching. Unmasking a bit that is already pending raises `irq`.
- Reset values:
  - STATE = 8'h0F (keys released, switches low).
  - PENDING = MASK = EDGE_MODE = 8'h00.
  - All counters and synchronizers are 0.
  - `readdata` = 8'h00, `irq` = 0.
- Reset mid-debounce discards partial counts. If switches are up after reset, they are re-debounced from STATE = 8'h0F and raise PENDING normally.

## Timing
- Input edge to STATE update: 2 + `DEBOUNCE_CYCLES` rising edges, provided the input stays stable throughout.
- PENDING sets on the same edge as the STATE update. `irq` rises 1 edge later.
- Read latency is 1 cycle: `readdata` at edge n+1 reflects `addr` and register contents at edge n.
  - A read issued in the same cycle as a write returns the pre-write value.
- A MASK or PENDING write takes effect at the strobe edge. `irq` reflects it 1 edge later.
- `irq` deasserts 1 edge after the last enabled pending bit clears.

## Structure
- Shared package `ez8_periph_pkg`:
  - address constants `KEC_ADDR_STATE/PENDING/MASK/EDGE`
  - `KEC_STATE_RESET = 8'h0F`
- Sub-module `debounce_bit`, instantiated 8 times.
  - Contains the synchronizer, counter and stable flop.
  - Takes a reset value per instance (1 for keys, 0 for switches).
  - Outputs `state` and a one-cycle `accept` pulse.
- The top level holds the PENDING/MASK/EDGE_MODE registers, the event qualification, the bus decode, and the `readdata`/`irq` flops.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- **Reset defaults.** Reset with keys = 4'hF, switches = 0, then read addr 0..3. Required: 0F, 00, 00, 00; `irq` = 0 throughout.
- **Glitch rejection.** Pulse `keys[0]` low for 3 cycles. Required: STATE stays 0F and PENDING stays 00. Then hold it low. Required: STATE = 0E exactly 6 edges after the edge, PENDING = 01.
- **Interrupt path.** Write MASK = 01 after PENDING[0] is set. Required: `irq` = 1 one edge later. Write PENDING = 01. Required: PENDING = 00 and `irq` = 0 one edge later.
- **Edge mode.** Write EDGE_MODE = 01, press then release `keys[0]`, each held for 10 cycles. Required: PENDING[0] sets on the press only; after a clear, the release leaves it 00.
- **Clear collision.** Arrange an accept of `switches[3]` (bit 7) on the same edge as a write of PENDING = 80. Required: PENDING[7] = 1.
- **Reset mid-operation.** With `switches` = 4'hF held, assert reset midway through debounce. Required: all registers at reset values, then STATE = FF and PENDING = F0 after 6 edges.

Source files
------------

// File: rtl/ez8_periph_pkg.sv
// Shared definitions for the ez8 peripheral slice: key/switch event controller register map.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
package ez8_periph_pkg;

    // Register select values on the 2-bit peripheral address.
    localparam logic [1:0] KEC_ADDR_STATE   = 2'd0;
    localparam logic [1:0] KEC_ADDR_PENDING = 2'd1;
    localparam logic [1:0] KEC_ADDR_MASK    = 2'd2;
    localparam logic [1:0] KEC_ADDR_EDGE    = 2'd3;

    // Keys are active-low and idle high; switches idle low.
    localparam logic [7:0] KEC_STATE_RESET  = 8'h0F;

    // Software-visible register set.
    typedef struct packed {
        logic [7:0] state;
        logic [7:0] pending;
        logic [7:0] mask;
        logic [7:0] edge_mode;
    } kec_regs_t;

    // Bits that latch a new event this cycle. A bit in edge mode only
    // reports a 1->0 transition, i.e. an accept while the stable value is
    // still 1 (the accepted new value is always the complement).
    function automatic logic [7:0] kec_qualify(
        input logic [7:0] accept,
        input logic [7:0] old_state,
        input logic [7:0] edge_mode
    );
        return accept & (~edge_mode | old_state);
    endfunction

    // Register read multiplexer.
    function automatic logic [7:0] kec_read_mux(
        input logic [1:0] sel,
        input kec_regs_t  regs
    );
        logic [7:0] val;
        case (sel)
            KEC_ADDR_STATE:   val = regs.state;
            KEC_ADDR_PENDING: val = regs.pending;
            KEC_ADDR_MASK:    val = regs.mask;
            default:          val = regs.edge_mode;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounced input: 2-flop synchronizer, stability counter, stable-value flop.
// Latency: raw edge to state update takes 2 + DEBOUNCE_CYCLES clock edges when held stable.
// Backpressure: none; accept is a single-cycle combinational pulse valid the cycle before state flips.
//
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   raw         - asynchronous raw input
//   state       - debounced stable value (resets to RESET_VAL)
//   accept      - high in the cycle whose rising edge updates state
module debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic state,
    output logic accept
);

    localparam int             CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync;
    logic [CW-1:0] cnt;
    logic          differs;

    assign differs = (sync != state);

    // Combinational so the top can latch the event on the same edge that
    // moves state; the accepted value is always ~state.
    assign accept  = differs && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            cnt       <= '0;
            state     <= RESET_VAL;
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;
            if (!differs) begin
                cnt <= '0;
            end else if (accept) begin
                state <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Debounces 4 keys + 4 switches into latched, maskable events with one level irq; 4x8-bit register port.
// Latency: reads 1 cycle; PENDING sets on the STATE-update edge; irq follows PENDING/MASK by 1 edge.
// Backpressure: none; every write strobe is taken, reads have no side effects.
//
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   keys        - raw push-keys, active-low, asynchronous
//   switches    - raw slide-switches, asynchronous
//   addr        - register select (STATE, PENDING, MASK, EDGE_MODE)
//   write_en    - one-cycle write strobe
//   writedata   - write data
//   readdata    - registered read data
//   irq         - registered level interrupt, |(PENDING & MASK)
module key_event_ctrl
    import ez8_periph_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keys,
    input  logic [3:0] switches,
    input  logic [1:0] addr,
    input  logic       write_en,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       irq
);

    logic [7:0] in_raw;
    logic [7:0] state;
    logic [7:0] accept;
    logic [7:0] pending;
    logic [7:0] mask;
    logic [7:0] edge_mode;
    logic [7:0] set_bits;
    logic [7:0] clr_bits;
    kec_regs_t  regs;

    assign in_raw = {switches, keys};

    for (genvar i = 0; i < 8; i++) begin : g_db
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (KEC_STATE_RESET[i])
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .raw    (in_raw[i]),
            .state  (state[i]),
            .accept (accept[i])
        );
    end

    // Event qualification uses the pre-update state so edge-mode bits can
    // tell a press (1->0) from a release.
    always_comb begin
        set_bits = kec_qualify(accept, state, edge_mode);
        clr_bits = (write_en && (addr == KEC_ADDR_PENDING)) ? writedata : 8'h00;
    end

    always_comb begin
        regs.state     = state;
        regs.pending   = pending;
        regs.mask      = mask;
        regs.edge_mode = edge_mode;
    end

    // Clear first, then OR in new events, so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 8'h00;
        end else begin
            pending <= (pending & ~clr_bits) | set_bits;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask      <= 8'h00;
            edge_mode <= 8'h00;
        end else if (write_en) begin
            if (addr == KEC_ADDR_MASK) begin
                mask <= writedata;
            end
            if (addr == KEC_ADDR_EDGE) begin
                edge_mode <= writedata;
            end
        end
    end

    // Both outputs sample the registers as they stand before this edge, so
    // a read in a write cycle returns the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 8'h00;
            irq      <= 1'b0;
        end else begin
            readdata <= kec_read_mux(addr, regs);
            irq      <= |(pending & mask);
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
module tb_key_event_ctrl;
    import ez8_periph_pkg::*;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] keys = 4'hF;
    logic [3:0] switches = 4'h0;
    logic [1:0] addr = 2'd0;
    logic       write_en = 1'b0;
    logic [7:0] writedata = 8'h00;
    logic [7:0] readdata;
    logic       irq;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    key_event_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .keys      (keys),
        .switches  (switches),
        .addr      (addr),
        .write_en  (write_en),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    // Reference model. Debounce is judged from the history of raw samples:
    // the synchronizer shows at edge k the raw value taken at edge k-2 (zero
    // for the first two edges after reset), and a bit flips when the last D
    // synchronized values all disagree with the current stable value.
    logic [7:0] m_state = KEC_STATE_RESET;
    logic [7:0] m_pend = 8'h00;
    logic [7:0] m_mask = 8'h00;
    logic [7:0] m_edge = 8'h00;
    logic [7:0] m_rd = 8'h00;
    logic       m_irq = 1'b0;
    logic [7:0] m_samp[$];
    logic [7:0] m_acc;
    logic [7:0] m_set;
    logic [7:0] m_clr;
    logic [7:0] m_tmp;
    logic       m_s;

    always @(posedge clk) begin
        if (reset) begin
            m_state = KEC_STATE_RESET;
            m_pend  = 8'h00;
            m_mask  = 8'h00;
            m_edge  = 8'h00;
            m_rd    = 8'h00;
            m_irq   = 1'b0;
            m_samp.delete();
        end else begin
            m_samp.push_back({switches, keys});
            m_acc = 8'h00;
            if (m_samp.size() >= D) begin
                for (int b = 0; b < 8; b++) begin
                    m_acc[b] = 1'b1;
                    for (int k = m_samp.size() - D + 1; k <= m_samp.size(); k++) begin
                        if (k >= 3) begin
                            m_tmp = m_samp[k-3];
                            m_s = m_tmp[b];
                        end else begin
                            m_s = 1'b0;
                        end
                        if (m_s == m_state[b]) m_acc[b] = 1'b0;
                    end
                end
            end
            // press-only bits: old value must be 1 (released)
            m_set = m_acc & (~m_edge | m_state);
            m_clr = (write_en && addr == 2'd1) ? writedata : 8'h00;
            case (addr)
                2'd0:    m_rd = m_state;
                2'd1:    m_rd = m_pend;
                2'd2:    m_rd = m_mask;
                default: m_rd = m_edge;
            endcase
            m_irq   = |(m_pend & m_mask);
            m_state = m_state ^ m_acc;
            m_pend  = (m_pend & ~m_clr) | m_set;
            if (write_en && addr == 2'd2) m_mask = writedata;
            if (write_en && addr == 2'd3) m_edge = writedata;
        end
    end

    task automatic test_reset();
        logic [7:0] exp_r [4];
        exp_r = '{8'h0F, 8'h00, 8'h00, 8'h00};
        reset = 1'b1; keys = 4'hF; switches = 4'h0; write_en = 1'b0; addr = 2'd0;
        repeat (3) @(negedge clk);
        total++;
        if (readdata !== 8'h00 || irq !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: readdata=%h irq=%b want 00/0", readdata, irq);
        end
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            addr = 2'(a);
            @(negedge clk);
            total++;
            if (readdata !== exp_r[a]) begin
                bad++; $display("FAIL reset_read addr%0d: got %h want %h", a, readdata, exp_r[a]);
            end
            total++;
            if (irq !== 1'b0) begin
                bad++; $display("FAIL reset_irq addr%0d: got %b want 0", a, irq);
            end
        end
    endtask

    task automatic test_glitch();
        addr = 2'd0;
        @(negedge clk);
        keys[0] = 1'b0;
        repeat (3) @(negedge clk);
        keys[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            total++;
            if (readdata !== 8'h0F) begin
                bad++; $display("FAIL glitch_state cyc%0d: got %h want 0F", c, readdata);
            end
        end
        addr = 2'd1;
        @(negedge clk);
        total++;
        if (readdata !== 8'h00) begin
            bad++; $display("FAIL glitch_pending: got %h want 00", readdata);
        end
        // Hold low: readdata shows edge-6 result one edge later.
        addr = 2'd0;
        keys[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            total++;
            if (readdata !== ((e == 7) ? 8'h0E : 8'h0F)) begin
                bad++; $display("FAIL press_latency edge%0d: got %h want %h", e, readdata,
                                (e == 7) ? 8'h0E : 8'h0F);
            end
            total++;
            if (readdata !== m_rd) begin
                bad++; $display("FAIL press_model edge%0d: got %h want %h", e, readdata, m_rd);
            end
        end
        addr = 2'd1;
        @(negedge clk);
        total++;
        if (readdata !== 8'h01 || irq !== 1'b0) begin
            bad++; $display("FAIL press_pending: got %h irq=%b want 01/0", readdata, irq);
        end
    endtask

    task automatic test_interrupt();
        addr = 2'd2; writedata = 8'h01; write_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0;
        total++;
        if (irq !== 1'b0) begin
            bad++; $display("FAIL irq_mask_early: got %b want 0", irq);
        end
        @(negedge clk);
        total++;
        if (irq !== 1'b1) begin
            bad++; $display("FAIL irq_rise: got %b want 1", irq);
        end
        addr = 2'd1; writedata = 8'h01; write_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0;
        total++;
        if (readdata !== 8'h01 || irq !== 1'b1) begin
            bad++; $display("FAIL read_during_write: got %h irq=%b want 01/1", readdata, irq);
        end
        @(negedge clk);
        total++;
        if (readdata !== 8'h00 || irq !== 1'b0) begin
            bad++; $display("FAIL irq_clear: got %h irq=%b want 00/0", readdata, irq);
        end
    endtask

    task automatic test_edge_mode();
        addr = 2'd3; writedata = 8'h01; write_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0;
        addr = 2'd1;
        keys[0] = 1'b1;     // release: ignored in edge mode
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (readdata !== 8'h00 || irq !== m_irq) begin
                bad++; $display("FAIL edge_release1 cyc%0d: got %h irq=%b want 00/%b", c, readdata, irq, m_irq);
            end
        end
        keys[0] = 1'b0;     // press
        repeat (10) @(negedge clk);
        total++;
        if (readdata !== 8'h01 || irq !== 1'b1) begin
            bad++; $display("FAIL edge_press: got %h irq=%b want 01/1", readdata, irq);
        end
        writedata = 8'h01; write_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0;
        @(negedge clk);
        total++;
        if (readdata !== 8'h00) begin
            bad++; $display("FAIL edge_clear: got %h want 00", readdata);
        end
        keys[0] = 1'b1;     // release again
        repeat (10) @(negedge clk);
        total++;
        if (readdata !== 8'h00 || irq !== 1'b0) begin
            bad++; $display("FAIL edge_release2: got %h irq=%b want 00/0", readdata, irq);
        end
    endtask

    task automatic test_collision();
        addr = 2'd1; write_en = 1'b0;
        switches[3] = 1'b1;
        repeat (5) @(negedge clk);
        writedata = 8'h80; write_en = 1'b1;   // strobe on the accept edge
        @(negedge clk);
        write_en = 1'b0;
        total++;
        if (readdata !== 8'h00) begin
            bad++; $display("FAIL collision_pre: got %h want 00", readdata);
        end
        @(negedge clk);
        total++;
        if (readdata !== 8'h80) begin
            bad++; $display("FAIL collision_set_wins: got %h want 80", readdata);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_r [3];
        exp_r = '{8'hF0, 8'h00, 8'h00};
        switches = 4'hF;
        repeat (3) @(negedge clk);
        reset = 1'b1; addr = 2'd0;
        repeat (2) @(negedge clk);
        total++;
        if (readdata !== 8'h00 || irq !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs: readdata=%h irq=%b want 00/0", readdata, irq);
        end
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            total++;
            if (readdata !== ((e == 7) ? 8'hFF : 8'h0F)) begin
                bad++; $display("FAIL midreset_state edge%0d: got %h want %h", e, readdata,
                                (e == 7) ? 8'hFF : 8'h0F);
            end
        end
        for (int a = 1; a < 4; a++) begin
            addr = 2'(a);
            @(negedge clk);
            total++;
            if (readdata !== exp_r[a-1] || irq !== 1'b0) begin
                bad++; $display("FAIL midreset_read addr%0d: got %h irq=%b want %h/0", a, readdata, irq, exp_r[a-1]);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        int b;
        hold = 0;
        for (int c = 0; c < 800; c++) begin
            if (hold == 0) begin
                b = int'($urandom_range(0, 7));
                if (b < 4) keys[b] = ~keys[b];
                else switches[b-4] = ~switches[b-4];
                hold = int'($urandom_range(1, 8));
            end
            hold--;
            addr = 2'($urandom_range(0, 3));
            write_en = ($urandom_range(0, 4) == 0);
            writedata = 8'($urandom);
            @(negedge clk);
            total++;
            if (readdata !== m_rd) begin
                bad++; $display("FAIL rand_readdata cyc%0d: got %h want %h", c, readdata, m_rd);
            end
            total++;
            if (irq !== m_irq) begin
                bad++; $display("FAIL rand_irq cyc%0d: got %b want %b", c, irq, m_irq);
            end
        end
        write_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_interrupt();
        test_edge_mode();
        test_collision();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
